ram16_fifo: RTL and testbench

Synchronous 16-entry FIFO controller built around the single-port 16x1 distributed RAM primitive, which it sequences as a WIDTH-bit bank. It sits directly upstream of the RAM, generating address, write-enable and data. It also consumes the asynchronous RAM output into a registered output stage. Intended for byte buffering between KCPSM3 I/O ports and peripherals (UART, SPI), with valid/ready handshakes on both sides.

---
 rtl/ram16_fifo_pkg.sv | 10 +
 rtl/ram16_fifo_if.sv | 27 ++
 rtl/ram16xw_sp.sv | 28 ++
 rtl/ram16_fifo.sv | 104 ++++++++++
 tb/tb_ram16_fifo.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ram16_fifo_pkg.sv
// ram16_fifo shared constants.
// Depth, pointer/count widths and maximum occupancy (RAM plus output register).
package ram16_fifo_pkg;

    localparam int DEPTH     = 16;
    localparam int PTR_W     = 4;
    localparam int COUNT_W   = 5;
    localparam int LEVEL_MAX = 17;

endpackage

// File: rtl/ram16_fifo_if.sv
// ram16_fifo handshake bundle.
// Write side: in_valid/in_data/in_ready. Read side: out_valid/out_data/out_ready.
// Status: level (0..17). Modports: master = producer/consumer, slave = FIFO.
interface ram16_fifo_if #(
    parameter int WIDTH = 8
) ();
    import ram16_fifo_pkg::*;

    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic [COUNT_W-1:0] level;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level
    );

endinterface

// File: rtl/ram16xw_sp.sv
// WIDTH-bit bank of 16x1 single-port RAM cells, shared address/WE/clk.
// Ports: clk, we, addr[3:0], d (write data), o (asynchronous read data).
module ram16xw_sp
    import ram16_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] addr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic [DEPTH-1:0] mem;

        // Contents are deliberately not reset, like the distributed RAM cell.
        always_ff @(posedge clk) begin
            if (we) begin
                mem[addr] <= d[i];
            end
        end

        assign o[i] = mem[addr];
    end

endmodule

// File: rtl/ram16_fifo.sv
// 17-entry FIFO: 16-deep single-port RAM bank plus a registered head.
// Ports: clk, reset_n (async, active low), bus (ram16_fifo_if.slave).
module ram16_fifo
    import ram16_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    ram16_fifo_if.slave  bus
);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] ram_count_q, ram_count_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;

    logic               slot_free;
    logic               ram_empty;
    logic               ram_full;
    logic               prefetch;
    logic               bypass;
    logic               write;
    logic               pop_empty;
    logic               ram_we;
    logic [PTR_W-1:0]   ram_addr;
    logic [WIDTH-1:0]   ram_o;

    assign slot_free = !out_valid_q || bus.out_ready;
    assign ram_empty = (ram_count_q == '0);
    assign ram_full  = (ram_count_q == COUNT_W'(DEPTH));

    // Refilling the head from RAM takes the single port, so it wins.
    assign prefetch  = !ram_empty && slot_free;
    assign bypass    = ram_empty && slot_free && bus.in_valid;
    assign write     = !prefetch && !bypass && !ram_full && bus.in_valid;
    assign pop_empty = ram_empty && slot_free && !bus.in_valid;

    // WE gated by reset so a write racing reset never lands in RAM.
    assign ram_we    = write && reset_n;
    assign ram_addr  = prefetch ? rd_ptr_q : wr_ptr_q;

    ram16xw_sp #(
        .WIDTH (WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .d    (bus.in_data),
        .o    (ram_o)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (1'b1)
            prefetch: begin
                out_data_d  = ram_o;
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                ram_count_d = ram_count_q - COUNT_W'(1);
            end
            bypass: begin
                out_data_d  = bus.in_data;
                out_valid_d = 1'b1;
            end
            write: begin
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                ram_count_d = ram_count_q + COUNT_W'(1);
            end
            pop_empty: begin
                out_valid_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = reset_n && !prefetch && !ram_full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.level     = ram_count_q + COUNT_W'(out_valid_q);

endmodule

// File: tb/tb_ram16_fifo.sv
// Self-checking bench for ram16_fifo: vector table plus scoreboard.
module tb_ram16_fifo;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    ram16_fifo_if #(.WIDTH(8)) bus ();

    ram16_fifo #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int popped = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
        int         exp_lvl;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, settle, score transfers, cross the edge.
    task automatic cyc(input logic iv, input logic [7:0] d,
                       input logic ordy, output logic rdy);
        logic [7:0] e;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        rdy = bus.in_ready;
        if (bus.out_valid && ordy) begin
            popped++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_data", int'(bus.out_data), int'(e));
            end
        end
        if (iv && bus.in_ready) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_level", int'(bus.level), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        logic rdy;
        int k;
        int sent;
        int budget;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1};
        vecs[1] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'hA5, 2};
        vecs[2] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'h5A, 1};
        vecs[3] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC3, 0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC3, 0};
        vecs[6] = '{1'b1, 8'h0F, 1'b0, 1'b1, 1'b1, 8'h0F, 1};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0F, 1};

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].iv, vecs[i].d, vecs[i].ordy, rdy);
            chk($sformatf("v%0d_in_ready", i), int'(rdy), int'(vecs[i].exp_rdy));
            chk($sformatf("v%0d_out_valid", i), int'(bus.out_valid), int'(vecs[i].exp_ov));
            chk($sformatf("v%0d_out_data", i), int'(bus.out_data), int'(vecs[i].exp_od));
            chk($sformatf("v%0d_level", i), int'(bus.level), vecs[i].exp_lvl);
        end

        // Reset with a word still held discards it.
        do_reset();

        // Fill to 17 with the consumer stalled.
        for (int i = 0; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, rdy);
            chk("fill_in_ready", int'(rdy), 1);
        end
        chk("full_level", int'(bus.level), 17);
        chk("full_head", int'(bus.out_data), 8'h00);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 8'h11, 1'b0, rdy);
            chk("full_hold_rdy", int'(rdy), 0);
            chk("full_hold_level", int'(bus.level), 17);
        end

        // Pop at full: prefetch keeps in_ready low, next cycle it rises.
        cyc(1'b1, 8'h11, 1'b1, rdy);
        chk("full_pop_rdy", int'(rdy), 0);
        chk("full_pop_level", int'(bus.level), 16);
        cyc(1'b1, 8'h11, 1'b0, rdy);
        chk("after_pop_rdy", int'(rdy), 1);
        chk("refill_level", int'(bus.level), 17);

        // Drain: 16 prefetches, then the final pop with nothing to load.
        for (int i = 0; i <= 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, rdy);
            chk("drain_rdy", int'(rdy), (i < 16) ? 0 : 1);
        end
        chk("drain_level", int'(bus.level), 0);
        chk("drain_out_valid", int'(bus.out_valid), 0);
        chk("drain_sb_empty", sb.size(), 0);

        // Randomised gaps, enough backlog to wrap the pointers.
        do_reset();
        popped = 0;
        sent = 0;
        budget = 0;
        while ((popped < 40) && (budget < 3000)) begin
            logic iv;
            logic ordy;
            iv   = (sent < 40) && ($urandom_range(0, 3) != 0);
            ordy = (sent >= 40) || ($urandom_range(0, 2) == 0);
            cyc(iv, 8'(8'h40 + sent), ordy, rdy);
            if (iv && rdy) sent++;
            budget++;
        end
        chk("wrap_popped", popped, 40);
        chk("wrap_sb_empty", sb.size(), 0);

        // Reset lands while a write is being accepted.
        do_reset();
        cyc(1'b1, 8'h11, 1'b0, rdy);
        cyc(1'b1, 8'h22, 1'b0, rdy);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        #1;
        chk("mid_pre_rdy", int'(bus.in_ready), 1);
        reset_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_level", int'(bus.level), 0);
        bus.in_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_after_level", int'(bus.level), 0);
        chk("mid_after_ov", int'(bus.out_valid), 0);
        cyc(1'b1, 8'h3C, 1'b0, rdy);
        chk("mid_3c_data", int'(bus.out_data), 8'h3C);
        chk("mid_3c_level", int'(bus.level), 1);
        k = popped;
        cyc(1'b0, 8'h00, 1'b1, rdy);
        chk("mid_3c_popped", popped - k, 1);
        chk("mid_final_level", int'(bus.level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
